uart_rx_sniffer: RTL and testbench

UART_RX_SNIFFER -- requirements
Module: uart_rx_sniffer

---
 rtl/uart_sniffer_pkg.sv | 7 +
 rtl/uart_sniffer_fifo.sv | 39 +++
 rtl/uart_rx_sniffer.sv | 122 ++++++++++++
 tb/tb_uart_rx_sniffer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_sniffer_pkg.sv
// uart_sniffer_pkg: receiver FSM state encoding and parity mode constants.
package uart_sniffer_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
endpackage

// File: rtl/uart_sniffer_fifo.sv
// uart_sniffer_fifo: first-word fall-through FIFO; a pop frees space for a same-cycle push.
module uart_sniffer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_pop, do_push;
  assign rd_valid = count != '0;
  assign full     = count == CW'(DEPTH);
  assign do_pop   = pop && rd_valid;
  assign do_push  = push && (!full || do_pop);
  assign rd_data  = rd_valid ? mem[rptr] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= do_push ? wptr + 1'b1 : wptr;
      rptr  <= do_pop ? rptr + 1'b1 : rptr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wr_data;
endmodule

// File: rtl/uart_rx_sniffer.sv
// uart_rx_sniffer: UART receiver feeding a FIFO with sticky error flags.
// Define UART_RX_SNIFFER_BREAK_DET_EN to report all-zero frames with a low stop bit as break_det.
module uart_rx_sniffer
  import uart_sniffer_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK100MHZ,
  input  logic                          ck_rst,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          clr_err,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow,
  output logic                          break_det
);
  logic s1, s2, s3;
  state_t state;
  logic [15:0] timer;
  logic [3:0] idx;
  logic [DATA_BITS-1:0] shreg;
  logic hold, tick, push, full, stop_bad, brk, exp_par;
  logic set_fe, set_pe, set_ov;
  assign tick     = timer == '0;
  assign push     = state == STOP && !hold && tick && s2;
  assign stop_bad = state == STOP && !hold && tick && !s2;
  assign exp_par  = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;
  assign set_pe   = state == PAR && tick && (s2 != exp_par);
  assign set_fe   = stop_bad && !brk;
  assign set_ov   = push && full && !rd_en;
  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      s3 <= s2;
    end
  end
  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      state <= IDLE;
      timer <= '0;
      idx   <= '0;
      shreg <= '0;
      hold  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s3 && !s2) begin
          state <= START;
          timer <= 16'(CLK_DIV / 2 - 1);
        end
        START: if (tick) begin
          state <= s2 ? IDLE : DATA;
          timer <= 16'(CLK_DIV - 1);
          idx   <= '0;
        end else timer <= timer - 1'b1;
        DATA: if (tick) begin
          shreg <= {s2, shreg[DATA_BITS-1:1]};
          idx   <= idx + 1'b1;
          timer <= 16'(CLK_DIV - 1);
          if (idx == 4'(DATA_BITS - 1)) state <= (PARITY != PAR_NONE) ? PAR : STOP;
        end else timer <= timer - 1'b1;
        PAR: if (tick) begin
          state <= STOP;
          timer <= 16'(CLK_DIV - 1);
        end else timer <= timer - 1'b1;
        STOP: if (hold) begin
          // bad stop bit: stay here until the line returns high
          if (s2) begin
            state <= IDLE;
            hold  <= 1'b0;
          end
        end else if (tick) begin
          if (s2) state <= IDLE;
          else hold <= 1'b1;
        end else timer <= timer - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef UART_RX_SNIFFER_BREAK_DET_EN
  assign brk = stop_bad && shreg == '0;
  always_ff @(posedge CLK100MHZ or negedge ck_rst)
    if (!ck_rst) break_det <= 1'b0;
    else break_det <= brk | (break_det & ~clr_err);
`else
  assign brk = 1'b0;
  assign break_det = 1'b0;
`endif
  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_err  <= set_fe | (frame_err & ~clr_err);
      parity_err <= set_pe | (parity_err & ~clr_err);
      overflow   <= set_ov | (overflow & ~clr_err);
    end
  end
  uart_sniffer_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (CLK100MHZ),
    .rst_n    (ck_rst),
    .push     (push),
    .wr_data  (shreg),
    .pop      (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .count    (fifo_count)
  );
endmodule

// File: tb/tb_uart_rx_sniffer.sv
// tb_uart_rx_sniffer: randomized frames with a scoreboard queue drained by a monitor process.
// Break expectations follow UART_RX_SNIFFER_BREAK_DET_EN.
module tb_uart_rx_sniffer;
  localparam int C = 20;
  localparam int H = C / 2;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, rd_en, clr_err = 1'b0;
  logic [7:0] rd_data;
  logic rd_valid, frame_err, parity_err, overflow, break_det;
  logic [CW-1:0] fifo_count;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  bit drain = 1'b0, force_pop = 1'b0;
  bit e_fe, e_pe, e_ov, e_bd;

  uart_rx_sniffer #(.CLK_DIV(C), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(DEPTH)) dut (
    .CLK100MHZ(clk), .ck_rst(rst_n), .rxd(rxd), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .fifo_count(fifo_count), .clr_err(clr_err), .frame_err(frame_err),
    .parity_err(parity_err), .overflow(overflow), .break_det(break_det)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rd_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_valid && (drain || force_pop)) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte got %0h expected none", rd_data);
        end else chk("rd_data", rd_data, q.pop_front());
        rd_en = 1'b1;
      end else rd_en = 1'b0;
    end
  end

  function automatic void model(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int pops);
    if (bad_par) e_pe = 1'b1;
    if (bad_stop) begin
`ifdef UART_RX_SNIFFER_BREAK_DET_EN
      if (d == 8'h00) e_bd = 1'b1;
      else e_fe = 1'b1;
`else
      e_fe = 1'b1;
`endif
    end else if (!drain && q.size() - pops >= DEPTH) e_ov = 1'b1;
    else q.push_back(d);
  endfunction

  task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    @(negedge clk) rxd = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (C) @(negedge clk);
    end
    rxd = (^d) ^ bad_par;
    repeat (C) @(negedge clk);
    rxd = !bad_stop;
    repeat (C) @(negedge clk);
    rxd = 1'b1;
    repeat (C) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    model(d, bad_par, bad_stop, 0);
    send(d, bad_par, bad_stop);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_frame_err"}, frame_err, e_fe);
    chk({tag, "_parity_err"}, parity_err, e_pe);
    chk({tag, "_overflow"}, overflow, e_ov);
    chk({tag, "_break_det"}, break_det, e_bd);
  endtask

  task automatic clear_flags(input string tag);
    @(negedge clk) clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
    {e_fe, e_pe, e_ov, e_bd} = '0;
    check_flags(tag);
  endtask

  task automatic wait_drain(input string tag);
    drain = 1'b1;
    for (int i = 0; i < 500 && q.size() != 0; i++) @(negedge clk);
    chk({tag, "_left_in_model"}, q.size(), 0);
    repeat (2) @(negedge clk);
    chk({tag, "_count"}, fifo_count, 0);
  endtask

  initial begin
    logic [7:0] b;
    repeat (3) @(negedge clk);
    chk("rst_count", fifo_count, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    check_flags("rst");
    rst_n = 1'b1;
    drain = 1'b1;
    repeat (5) @(negedge clk);
    xfer(8'h55, 0, 0);
    xfer(8'hA3, 0, 0);
    xfer(8'h0D, 0, 0);
    wait_drain("basic");
    check_flags("basic");
    // bad parity with clr_err landing on the very cycle the flag is set
    model(8'h07, 1, 0, 0);
    fork
      send(8'h07, 1, 0);
      begin
        @(negedge clk);
        repeat (2 + H + 9 * C) @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
      end
    join
    wait_drain("parity");
    check_flags("parity");
    clear_flags("parity_clr");
    @(negedge clk) rxd = 1'b0;
    repeat (6) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * C) @(negedge clk);
    chk("glitch_count", fifo_count, 0);
    check_flags("glitch");
    xfer(8'h41, 0, 1);
    chk("frame_count", fifo_count, 0);
    check_flags("frame");
    clear_flags("frame_clr");
    xfer(8'h00, 0, 1);
    chk("break_count", fifo_count, 0);
    check_flags("break");
    clear_flags("break_clr");
    drain = 1'b0;
    for (int i = 0; i < 5; i++) xfer(8'($urandom), 0, 0);
    chk("ovf_count", fifo_count, DEPTH);
    check_flags("ovf");
    clear_flags("ovf_clr");
    b = 8'($urandom);
    model(b, 0, 0, 1);
    fork
      send(b, 0, 0);
      begin
        @(negedge clk);
        repeat (2 + H + 10 * C) @(posedge clk);
        #1 force_pop = 1'b1;
        @(posedge clk);
        #1 force_pop = 1'b0;
      end
    join
    chk("full_pushpop_count", fifo_count, DEPTH);
    check_flags("full_pushpop");
    wait_drain("full_drain");
    // abandon a frame midway through its data bits with reset
    @(negedge clk) rxd = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0];
      repeat (C) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_count", fifo_count, 0);
    chk("midrst_valid", rd_valid, 0);
    check_flags("midrst");
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    repeat (2 * C) @(negedge clk);
    xfer(8'h3C, 0, 0);
    wait_drain("after_rst");
    check_flags("after_rst");
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 5; i++)
        xfer(8'($urandom), $urandom_range(5) == 0, $urandom_range(7) == 0);
      wait_drain("rand");
      check_flags("rand");
      clear_flags("rand_clr");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
